// File: rtl/br_resolve_unit.sv
// Branch resolution: in-order prediction queue, mispredict detection,
// one-cycle flush/redirect, predictor training and saturating counters.
module br_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [31:0]      if_pc,
    input  logic             if_pred_dir,
    input  logic [31:0]      if_pred_target,
    output logic             q_full,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic [6:0]       ex_opcode,
    input  logic             ex_br_en,
    input  logic [31:0]      ex_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             upd_valid,
    output logic [31:0]      upd_pc,
    output logic             upd_taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispredict_count,
    output logic             seq_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [6:0] OP_BR = 7'h63;

    typedef struct packed {
        logic [31:0] pc;
        logic        dir;
        logic [31:0] target;
    } pq_entry_t;

    pq_entry_t      mem [DEPTH];
    pq_entry_t      head;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;

    logic        empty;
    logic        push;
    logic        resolve;
    logic        pop;
    logic        is_br;
    logic        pd;
    logic        dir_err;
    logic        tgt_err;
    logic        pc_err;
    logic        mispredict;
    logic [31:0] next_pc;

    assign empty   = (count == '0);
    assign q_full  = (count == (AW+1)'(DEPTH));

    // Nothing resolved while flush is high is on the correct path.
    assign resolve = ex_valid & ~stall & ~flush;
    assign push    = if_valid & ~stall & ~q_full & ~flush;
    assign pop     = resolve & ~empty;
    assign is_br   = (ex_opcode == OP_BR);

    assign head    = mem[rd_ptr];
    assign pd      = empty ? 1'b0 : head.dir;

    assign dir_err = (pd != ex_br_en);
    assign tgt_err = pd & ex_br_en & (head.target != ex_target);
    assign pc_err  = ~empty & (head.pc != ex_pc);

    assign mispredict = empty | dir_err | tgt_err | pc_err;
    assign next_pc    = ex_br_en ? ex_target : ex_pc + 32'd4;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: if_pc, dir: if_pred_dir, target: if_pred_target};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push & ~pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop & ~push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flush       <= 1'b0;
            redirect_pc <= '0;
            upd_valid   <= 1'b0;
            upd_pc      <= '0;
            upd_taken   <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            flush     <= resolve & mispredict;
            upd_valid <= resolve & is_br;
            if (resolve & mispredict) begin
                redirect_pc <= next_pc;
            end
            if (resolve & is_br) begin
                upd_pc    <= ex_pc;
                upd_taken <= ex_br_en;
            end
            if (resolve & (empty | pc_err)) begin
                seq_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count         <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve & is_br & ~(&br_count)) begin
                br_count <= br_count + CNT_W'(1);
            end
            if (resolve & mispredict & ~(&mispredict_count)) begin
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Resolution side of the branch predictor interface. Captures each fetch-stage prediction in an in-order prediction queue and compares it with the actual outcome when the instruction resolves at EX/MEM.
- Outputs a one-cycle flush plus redirect PC on a mispredict.
- Drives the predictor training port: upd_valid / upd_pc / upd_taken, with upd_* mapping to ex_mem_br_en / ex_mem_pc.
- Keeps saturating branch and mispredict counters.

Parameters:
- DEPTH, 4, prediction queue entries; power of two, ≥ 2.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  pipeline stall; blocks push, pop and counter updates
- if_valid  in  1  fetch presents a control-flow instruction with prediction
- if_pc  in  32  PC of predicted instruction
- if_pred_dir  in  1  predicted taken
- if_pred_target  in  32  predicted target; ignored when if_pred_dir = 0
- q_full  out  1  queue full; fetch must hold if_* until deasserted
- ex_valid  in  1  EX/MEM holds a resolving control-flow instruction
- ex_pc  in  32  its PC
- ex_opcode  in  7  its opcode: op_br 7'h63, op_jal 7'h6f, op_jalr 7'h67
- ex_br_en  in  1  actual taken; jal/jalr always present 1
- ex_target  in  32  actual taken target
- flush  out  1  squash younger instructions
- redirect_pc  out  32  correct next PC, valid while flush = 1
- upd_valid  out  1  predictor training strobe
- upd_pc  out  32  training PC
- upd_taken  out  1  training outcome
- br_count  out  CNT_W  resolved op_br count
- mispredict_count  out  CNT_W  mispredict count, all opcodes
- seq_err  out  1  sticky: resolution with empty queue or PC mismatch

Behaviour:
- Reset: queue empty (rd_ptr = wr_ptr = 0, count = 0); flush, upd_valid, upd_taken, seq_err = 0; redirect_pc, upd_pc = 0; counters = 0; q_full = 0.
- Queue: circular FIFO. Entry = {pc, pred_dir, pred_target}. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- q_full = (count == DEPTH), combinational from state.
- Push condition: if_valid & !stall & !q_full & !flush.
- Pop condition: ex_valid & !stall & count != 0.
- Push and pop may occur in the same cycle, including when full: the push is still blocked by q_full (no bypass), and count decrements.
- Resolution, evaluated combinationally in the pop cycle. Head prediction is pd = head.pred_dir, pt = head.pred_target. mispredict when any of:
  - pd != ex_br_en;
  - pd & ex_br_en & (pt != ex_target);
  - queue empty;
  - head.pc != ex_pc.
- When the queue is empty, resolution is still performed if ex_valid & !stall, using a default prediction of not-taken.
- Empty-queue resolution and head.pc != ex_pc each set seq_err. seq_err clears only on rst.
- Outputs are registered and appear one cycle after resolution (1-cycle latency):
  - flush = 1 for exactly one cycle;
  - redirect_pc = ex_br_en ? ex_target : ex_pc + 32'd4 (mod 2^32).
- On that flush cycle the queue is cleared (rd_ptr = wr_ptr, count = 0). All remaining entries are wrong-path. Any push in the flush cycle is discarded.
- Training: upd_valid = 1 for one cycle, registered one cycle after resolution, only when ex_opcode == op_br, whether correct or mispredicted. upd_pc = ex_pc, upd_taken = ex_br_en. jal/jalr never train.
- Counters: br_count += 1 on each op_br resolution; mispredict_count += 1 on each mispredict. Both saturate at all-ones and are frozen while stall = 1.
- Stall: a resolution with stall = 1 has no effect; ex_* are re-evaluated when stall drops. Registered flush/upd pulses still deassert after one cycle regardless of stall.
- Back-to-back resolutions: a resolution in the cycle where flush = 1 is ignored (wrong-path).
- rst mid-operation: synchronous reset dominates; all state returns to reset values the next edge.

Test Plan:
- Reset, then push {pc=0x100, dir=0}, resolve ex_pc=0x100, op_br, br_en=0:
  - flush stays 0;
  - next cycle upd_valid=1, upd_pc=0x100, upd_taken=0;
  - br_count=1, mispredict_count=0.
- Push {0x200, dir=0}; resolve op_br br_en=1 target=0x240:
  - cycle+1: flush=1, redirect_pc=0x240, upd_taken=1, mispredict_count=1;
  - cycle+2: flush=0, queue empty.
- Push {0x300, dir=1, target=0x380}; resolve op_jalr br_en=1 target=0x390:
  - flush=1, redirect_pc=0x390, upd_valid=0, br_count unchanged.
- Push DEPTH=4 entries:
  - q_full=1 and a 5th if_valid is not accepted;
  - one correct-resolution pop with if_valid held: that cycle q_full=1 and no push, count=3; next cycle q_full=0 and the held entry is accepted, count=4.
- Push {0x400, dir=1, 0x480}, then {0x404..}, {0x408..}; resolve 0x400 br_en=0:
  - flush=1, redirect_pc=0x404;
  - queue emptied; push presented in the flush cycle is dropped.
- Resolve with empty queue, ex_pc=0x500, br_en=1, target=0x600:
  - flush=1, redirect_pc=0x600, seq_err=1, and it stays 1 until rst.
